alu_sequencer: RTL

//   Multi-cycle sequencer for the 4-bit ALU operation set (AND..MULT).

---
 rtl/alu_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the 4-bit ALU operation set: one op per start/busy
// handshake, single-cycle logical/arith/shift and iterative shift-add MULT.
module alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               cout,
  output logic               err,
  output logic [CNT_W-1:0]   op_count
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_MULT = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   x_l;
  logic [WIDTH-1:0]   y_l;
  logic               cin_l;
  logic [3:0]         op_l;
  logic [SW-1:0]      iter;

  logic [WIDTH-1:0]   exec_lo;
  logic               exec_cout;
  logic               exec_err;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] addend;

  // Single-cycle datapath on the latched operands, consumed in EXEC.
  always_comb begin
    exec_lo   = '0;
    exec_cout = 1'b0;
    exec_err  = 1'b0;
    sum       = '0;
    case (op_l)
      4'b0000: exec_lo = x_l & y_l;
      4'b0001: exec_lo = ~(x_l & y_l);
      4'b0010: exec_lo = x_l | y_l;
      4'b0011: exec_lo = ~(x_l | y_l);
      4'b0100: exec_lo = x_l ^ y_l;
      4'b0101: exec_lo = ~(x_l ^ y_l);
      4'b0110: exec_lo = ~x_l;
      4'b0111: exec_lo = x_l << y_l[SW-1:0];
      4'b1000: begin
        sum       = {1'b0, x_l} + {1'b0, y_l} + {{WIDTH{1'b0}}, cin_l};
        exec_lo   = sum[WIDTH-1:0];
        exec_cout = sum[WIDTH];
      end
      4'b1001: begin
        sum       = {1'b0, x_l} + {1'b0, ~y_l} + {{WIDTH{1'b0}}, cin_l};
        exec_lo   = sum[WIDTH-1:0];
        exec_cout = sum[WIDTH];
      end
      OP_MULT: exec_lo = '0;
      default: exec_err = 1'b1;
    endcase
  end

  assign addend = {{WIDTH{1'b0}}, x_l} << iter;

  // DONE spans two cycles: the first raises the done pulse, the second
  // drops it and releases busy, so done always lags the result by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      err      <= 1'b0;
      op_count <= '0;
      iter     <= '0;
      x_l      <= '0;
      y_l      <= '0;
      cin_l    <= 1'b0;
      op_l     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_l    <= x;
            y_l    <= y;
            cin_l  <= cin;
            op_l   <= op;
            busy   <= 1'b1;
            result <= '0;
            cout   <= 1'b0;
            err    <= 1'b0;
            iter   <= '0;
            state  <= (op == OP_MULT) ? MUL : EXEC;
          end
        end
        EXEC: begin
          result <= {{WIDTH{1'b0}}, exec_lo};
          cout   <= exec_cout;
          err    <= exec_err;
          state  <= DONE;
        end
        MUL: begin
          if (y_l[iter]) result <= result + addend;
          iter <= iter + SW'(1);
          if (iter == SW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (!done) begin
            done     <= 1'b1;
            op_count <= op_count + CNT_W'(1);
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
